round_sequencer: RTL and testbench



---
 rtl/round_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/round_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared phase encoding and counter widths for the round sequencer.
package round_pkg;

    localparam int SEC_W   = 8;
    localparam int ROUND_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        SCORE     = 3'd3,
        GAME_OVER = 3'd4
    } phase_e;

    function automatic logic is_timed(phase_e p);
        return (p == COUNTDOWN) || (p == PLAY) || (p == SCORE);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Cycle prescaler: wraps every TICKS_PER_SEC enabled cycles.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 74_250_000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear_in,
    input  logic en_in,
    output logic tick_out
);

    localparam int CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] count;

    assign tick_out = en_in && (count == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else if (clear_in || tick_out) begin
            count <= '0;
        end else if (en_in) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Round controller: COUNTDOWN -> PLAY -> SCORE per round, MAX_ROUNDS
// rounds per game, with per-phase seconds timer and pass tally.
module round_sequencer
    import round_pkg::*;
#(
    parameter int TICKS_PER_SEC = 74_250_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int PLAY_SEC      = 10,
    parameter int SCORE_SEC     = 5,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         start_in,
    input  logic         abort_in,
    input  logic         pause_in,
    input  logic         hit_in,
    output logic [2:0]   phase_out,
    output logic [7:0]   sec_left_out,
    output logic [7:0]   round_out,
    output logic [7:0]   pass_count_out,
    output logic         sec_tick_out,
    output logic         round_done_out,
    output logic         round_pass_out
);

    if (TICKS_PER_SEC < 2) begin : g_bad_tps
        $error("TICKS_PER_SEC must be >= 2");
    end
    if (COUNTDOWN_SEC < 1 || COUNTDOWN_SEC > 255) begin : g_bad_cd
        $error("COUNTDOWN_SEC out of range 1..255");
    end
    if (PLAY_SEC < 1 || PLAY_SEC > 255) begin : g_bad_play
        $error("PLAY_SEC out of range 1..255");
    end
    if (SCORE_SEC < 1 || SCORE_SEC > 255) begin : g_bad_score
        $error("SCORE_SEC out of range 1..255");
    end
    if (MAX_ROUNDS < 1 || MAX_ROUNDS > 255) begin : g_bad_rounds
        $error("MAX_ROUNDS out of range 1..255");
    end

    phase_e               phase_q;
    phase_e               phase_d;
    logic                 running;
    logic                 tick;
    logic                 expire;
    logic                 go;
    logic                 clear;
    logic                 last_round;
    logic                 hit_now;
    logic                 hit_q;
    logic                 hit_d;
    logic                 passed;
    logic [SEC_W-1:0]     sec_d;
    logic [SEC_W-1:0]     load_sec;
    logic [ROUND_W-1:0]   round_d;
    logic [ROUND_W-1:0]   pass_d;
    logic                 tick_d;
    logic                 done_d;
    logic                 rpass_d;

    assign running    = is_timed(phase_q) && !pause_in;
    assign go         = start_in
                     && (phase_q == IDLE || phase_q == GAME_OVER);
    assign expire     = tick && (sec_left_out == SEC_W'(1));
    assign last_round = (round_out == ROUND_W'(MAX_ROUNDS));
    assign hit_now    = hit_in && (phase_q == PLAY) && !pause_in;
    assign passed     = !(hit_q || hit_now);
    // Any phase change restarts the second from zero.
    assign clear      = (phase_d != phase_q);
    assign phase_out  = phase_q;

    tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear_in (clear),
        .en_in    (running),
        .tick_out (tick)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            phase_q <= IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (abort_in) begin
            phase_d = IDLE;
        end else if (go) begin
            phase_d = COUNTDOWN;
        end else if (expire) begin
            unique case (phase_q)
                COUNTDOWN: phase_d = PLAY;
                PLAY:      phase_d = SCORE;
                SCORE:     phase_d = last_round ? GAME_OVER : COUNTDOWN;
                default:   phase_d = phase_q;
            endcase
        end
    end

    always_comb begin
        load_sec = '0;
        unique case (phase_d)
            COUNTDOWN: load_sec = SEC_W'(COUNTDOWN_SEC);
            PLAY:      load_sec = SEC_W'(PLAY_SEC);
            SCORE:     load_sec = SEC_W'(SCORE_SEC);
            default:   load_sec = '0;
        endcase
    end

    always_comb begin
        sec_d   = sec_left_out;
        round_d = round_out;
        pass_d  = pass_count_out;
        hit_d   = hit_q || hit_now;
        rpass_d = round_pass_out;
        tick_d  = tick;
        done_d  = 1'b0;
        if (abort_in) begin
            sec_d   = '0;
            round_d = '0;
            pass_d  = '0;
            hit_d   = 1'b0;
            rpass_d = 1'b0;
            tick_d  = 1'b0;
        end else begin
            if (go) begin
                round_d = ROUND_W'(1);
                pass_d  = '0;
                hit_d   = 1'b0;
            end
            if (expire && phase_q == COUNTDOWN) begin
                hit_d = 1'b0;
            end
            if (expire && phase_q == PLAY) begin
                done_d  = 1'b1;
                rpass_d = passed;
                if (passed) begin
                    pass_d = pass_count_out + ROUND_W'(1);
                end
            end
            if (expire && phase_q == SCORE && !last_round) begin
                round_d = round_out + ROUND_W'(1);
            end
            if (clear) begin
                sec_d = load_sec;
            end else if (tick && sec_left_out > SEC_W'(1)) begin
                sec_d = sec_left_out - SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sec_left_out   <= '0;
            round_out      <= '0;
            pass_count_out <= '0;
            hit_q          <= 1'b0;
            round_pass_out <= 1'b0;
            sec_tick_out   <= 1'b0;
            round_done_out <= 1'b0;
        end else begin
            sec_left_out   <= sec_d;
            round_out      <= round_d;
            pass_count_out <= pass_d;
            hit_q          <= hit_d;
            round_pass_out <= rpass_d;
            sec_tick_out   <= tick_d;
            round_done_out <= done_d;
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with a short-second config.
module tb_round_sequencer;
    import round_pkg::*;

    localparam int TPS = 4;
    localparam int CD  = 2;
    localparam int PL  = 3;
    localparam int SC  = 1;
    localparam int MR  = 2;

    typedef struct {
        logic pass;
        int   cnt;
    } exp_t;

    logic       clk_in   = 1'b0;
    logic       rst_n_in = 1'b1;
    logic       start_in = 1'b0;
    logic       abort_in = 1'b0;
    logic       pause_in = 1'b0;
    logic       hit_in   = 1'b0;
    logic [2:0] phase_out;
    logic [7:0] sec_left_out;
    logic [7:0] round_out;
    logic [7:0] pass_count_out;
    logic       sec_tick_out;
    logic       round_done_out;
    logic       round_pass_out;

    int   n_chk     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   tick_cnt  = 0;
    int   last_tick = -1;
    bit   gap_chk   = 1'b0;
    exp_t exp_q[$];

    round_sequencer #(
        .TICKS_PER_SEC (TPS),
        .COUNTDOWN_SEC (CD),
        .PLAY_SEC      (PL),
        .SCORE_SEC     (SC),
        .MAX_ROUNDS    (MR)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .abort_in       (abort_in),
        .pause_in       (pause_in),
        .hit_in         (hit_in),
        .phase_out      (phase_out),
        .sec_left_out   (sec_left_out),
        .round_out      (round_out),
        .pass_count_out (pass_count_out),
        .sec_tick_out   (sec_tick_out),
        .round_done_out (round_done_out),
        .round_pass_out (round_pass_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in && sec_tick_out) begin
            tick_cnt++;
            if (gap_chk && last_tick >= 0)
                check("tick_gap", cyc - last_tick, TPS);
            last_tick = cyc;
        end
        if (rst_n_in && round_done_out) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("round_pass", int'(round_pass_out), int'(e.pass));
                check("done_pass_cnt", int'(pass_count_out), e.cnt);
            end
        end
    end

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic run_phase(input string tag, input phase_e ph,
                             input int exp_len, input int hit_at,
                             input int pause_at, input int pause_len,
                             input int start_at);
        int n;
        logic [7:0] frozen;
        n = 0;
        frozen = sec_left_out;
        while (phase_out == ph && n < 200) begin
            if (pause_len > 0 && n == pause_at)
                frozen = sec_left_out;
            if (pause_len > 0 && n > pause_at && n <= pause_at + pause_len) begin
                check({tag, "_frozen_sec"}, int'(sec_left_out), int'(frozen));
                check({tag, "_paused_tick"}, int'(sec_tick_out), 0);
            end
            hit_in   = (n == hit_at);
            pause_in = (n >= pause_at) && (n < pause_at + pause_len);
            start_in = (n == start_at);
            @(negedge clk_in);
            n++;
        end
        hit_in   = 1'b0;
        pause_in = 1'b0;
        start_in = 1'b0;
        check({tag, "_len"}, n, exp_len);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_phase"}, int'(phase_out), int'(IDLE));
        check({tag, "_sec"}, int'(sec_left_out), 0);
        check({tag, "_round"}, int'(round_out), 0);
        check({tag, "_pass"}, int'(pass_count_out), 0);
        check({tag, "_tick"}, int'(sec_tick_out), 0);
        check({tag, "_done"}, int'(round_done_out), 0);
        check({tag, "_rpass"}, int'(round_pass_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #1 rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check_reset_vals("rst");
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("idle_hold", int'(phase_out), int'(IDLE));

        // Game 1: no hits
        exp_q.push_back('{pass: 1'b1, cnt: 1});
        exp_q.push_back('{pass: 1'b1, cnt: 2});
        tick_cnt  = 0;
        last_tick = -1;
        gap_chk   = 1'b1;
        pulse_start();
        check("g1_sec", int'(sec_left_out), CD);
        check("g1_round", int'(round_out), 1);
        run_phase("g1_cd1", COUNTDOWN, 8, -1, -1, 0, -1);
        run_phase("g1_pl1", PLAY, 12, -1, -1, 0, -1);
        run_phase("g1_sc1", SCORE, 4, -1, -1, 0, -1);
        run_phase("g1_cd2", COUNTDOWN, 8, -1, -1, 0, -1);
        run_phase("g1_pl2", PLAY, 12, -1, -1, 0, -1);
        run_phase("g1_sc2", SCORE, 4, -1, -1, 0, -1);
        check("g1_phase", int'(phase_out), int'(GAME_OVER));
        check("g1_round_end", int'(round_out), 2);
        check("g1_pass_end", int'(pass_count_out), 2);
        check("g1_sec_end", int'(sec_left_out), 0);
        @(negedge clk_in);
        check("g1_ticks", tick_cnt, 12);
        check("g1_go_hold", int'(phase_out), int'(GAME_OVER));

        // Game 2: restart from GAME_OVER, hits in both rounds
        last_tick = -1;
        exp_q.push_back('{pass: 1'b0, cnt: 0});
        exp_q.push_back('{pass: 1'b0, cnt: 0});
        pulse_start();
        check("g2_phase", int'(phase_out), int'(COUNTDOWN));
        check("g2_round", int'(round_out), 1);
        check("g2_pass", int'(pass_count_out), 0);
        check("g2_sec", int'(sec_left_out), CD);
        run_phase("g2_cd1", COUNTDOWN, 8, -1, -1, 0, -1);
        run_phase("g2_pl1", PLAY, 12, 4, -1, 0, -1);
        run_phase("g2_sc1", SCORE, 4, -1, -1, 0, -1);
        run_phase("g2_cd2", COUNTDOWN, 8, -1, -1, 0, -1);
        run_phase("g2_pl2", PLAY, 12, 11, -1, 0, -1);
        run_phase("g2_sc2", SCORE, 4, -1, -1, 0, -1);
        check("g2_phase_end", int'(phase_out), int'(GAME_OVER));
        check("g2_round_end", int'(round_out), 2);
        check("g2_pass_end", int'(pass_count_out), 0);
        @(negedge clk_in);
        gap_chk = 1'b0;

        // Game 3: pauses, ignored hit and start, abort in SCORE
        exp_q.push_back('{pass: 1'b1, cnt: 1});
        pulse_start();
        run_phase("g3_cd1", COUNTDOWN, 15, -1, 3, 7, -1);
        run_phase("g3_pl1", PLAY, 14, 5, 5, 2, 8);
        check("g3_phase", int'(phase_out), int'(SCORE));
        check("g3_round", int'(round_out), 1);
        check("g3_pass", int'(pass_count_out), 1);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check_reset_vals("abort");
        repeat (3) @(negedge clk_in);
        check("abort_idle", int'(phase_out), int'(IDLE));

        // Asynchronous reset mid-PLAY
        pulse_start();
        run_phase("g4_cd1", COUNTDOWN, 8, -1, -1, 0, -1);
        repeat (5) @(negedge clk_in);
        check("g4_in_play", int'(phase_out), int'(PLAY));
        #2 rst_n_in = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        check("post_rst_phase", int'(phase_out), int'(IDLE));
        check("post_rst_round", int'(round_out), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
